// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush scheduler with memory-wait watchdog
// Optional event counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 0,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       rs1_ID,
   input  logic [4:0]       rs2_ID,
   input  logic             use_rs1_ID,
   input  logic             use_rs2_ID,
   input  logic [4:0]       rd_EX,
   input  logic             ID_EX_memRead,
   input  logic             mispredict_EX,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             PCWrite,
   output logic             IF_ID_write,
   output logic             IF_ID_flush,
   output logic             ID_EX_write,
   output logic             ID_EX_flush,
   output logic             EX_MEM_write,
   output logic             MEM_WB_bubble,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] lu_stall_cnt,
   output logic [CNT_W-1:0] mem_stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERROR} state_t;

   state_t          state_q, state_d;
   logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
   logic            mem_timeout_q, mem_timeout_d;

   logic mem_busy;
   logic load_use;
   logic freeze;

   assign mem_busy = dmem_req & ~dmem_ready;
   assign load_use = ID_EX_memRead & (rd_EX != 5'd0) &
                     ((use_rs1_ID & (rs1_ID == rd_EX)) | (use_rs2_ID & (rs2_ID == rd_EX)));
   assign freeze   = mem_busy | (state_q == S_ERROR);

   always_comb begin
      PCWrite       = 1'b1;
      IF_ID_write   = 1'b1;
      IF_ID_flush   = 1'b0;
      ID_EX_write   = 1'b1;
      ID_EX_flush   = 1'b0;
      EX_MEM_write  = 1'b1;
      MEM_WB_bubble = 1'b0;
      if (!reset) begin
         if (freeze) begin
            PCWrite       = 1'b0;
            IF_ID_write   = 1'b0;
            ID_EX_write   = 1'b0;
            EX_MEM_write  = 1'b0;
            MEM_WB_bubble = 1'b1;
         end else if (mispredict_EX) begin
            IF_ID_flush = 1'b1;
            ID_EX_flush = 1'b1;
         end else if (load_use) begin
            PCWrite     = 1'b0;
            IF_ID_write = 1'b0;
            ID_EX_flush = 1'b1;
         end
      end
   end

   // Ready arriving in the expiry cycle wins because the ~mem_busy test comes first.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      case (state_q)
         S_RUN: begin
            if (mem_busy) begin
               state_d    = S_WAIT;
               wait_cnt_d = WC_W'(1);
            end
         end
         S_WAIT: begin
            if (!mem_busy) begin
               state_d    = S_RUN;
               wait_cnt_d = '0;
            end else if ((MEM_TIMEOUT != 0) && (wait_cnt_q == WC_W'(MEM_TIMEOUT))) begin
               state_d       = S_ERROR;
               mem_timeout_d = 1'b1;
            end else if (wait_cnt_q != '1) begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         S_ERROR: mem_timeout_d = 1'b1;
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_RUN;
         wait_cnt_q    <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
   logic             flush_win, lu_win;
   logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
   logic [CNT_W-1:0] ms_cnt_q, ms_cnt_d;
   logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;

   assign flush_win = ~freeze & mispredict_EX;
   assign lu_win    = ~freeze & ~mispredict_EX & load_use;

   always_comb begin
      lu_cnt_d = lu_cnt_q;
      ms_cnt_d = ms_cnt_q;
      fl_cnt_d = fl_cnt_q;
      if (lu_win && (lu_cnt_q != '1)) lu_cnt_d = lu_cnt_q + 1'b1;
      if (freeze && (ms_cnt_q != '1)) ms_cnt_d = ms_cnt_q + 1'b1;
      if (flush_win && (fl_cnt_q != '1)) fl_cnt_d = fl_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         lu_cnt_q <= '0;
         ms_cnt_q <= '0;
         fl_cnt_q <= '0;
      end else begin
         lu_cnt_q <= lu_cnt_d;
         ms_cnt_q <= ms_cnt_d;
         fl_cnt_q <= fl_cnt_d;
      end
   end

   assign lu_stall_cnt  = lu_cnt_q;
   assign mem_stall_cnt = ms_cnt_q;
   assign flush_cnt     = fl_cnt_q;
`else
   assign lu_stall_cnt  = '0;
   assign mem_stall_cnt = '0;
   assign flush_cnt     = '0;
`endif

endmodule
